// File: rtl/wb_deserializer_out_pkg.sv
// WBDeserializer: shared constants and types for the Wishbone serial-link receiver.
// Symbol and packet geometry, register addresses, STATUS and CTRL bit positions,
// and the receive FSM state type.
package WBDeserializer;
    localparam int SYM_W    = 9;
    localparam int NUM_SYMS = 3;
    localparam int PKT_W    = SYM_W * NUM_SYMS;

    localparam logic [1:0] ADR_CTRL   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_DATA   = 2'd2;
    localparam int         NUM_REGS   = 3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam int ST_OVF   = 31;
    localparam int ST_BUSY  = 6;
    localparam int ST_FULL  = 5;
    localparam int ST_EMPTY = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } rx_state_t;
endpackage

// File: rtl/wb_deserializer_out_rx.sv
// deserializer_out: frames a start bit plus PKT_W data bits (MSB first) into one packet.
// Ports: clk_i/rst_i clock and async active-high reset; enable_i gates new start bits;
// data_i serial input; pkt_o assembled packet; pkt_valid_o one-cycle packet strobe;
// busy_o high while a frame is in flight.
module deserializer_out
    import WBDeserializer::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             data_i,
    output logic [PKT_W-1:0] pkt_o,
    output logic             pkt_valid_o,
    output logic             busy_o
);
    localparam int CNT_W = $clog2(PKT_W);

    rx_state_t        r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [PKT_W-1:0] r_shift;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == SHIFT) ? r_cnt + 1'b1 : '0;
            if (r_state == SHIFT)
                r_shift <= {r_shift[PKT_W-2:0], data_i};
        end
    end

    // enable only gates the start bit; a frame already in SHIFT always completes
    always_comb begin
        w_next      = r_state;
        pkt_valid_o = r_state == PUSH;
        busy_o      = r_state != IDLE;
        unique case (r_state)
            IDLE:    w_next = (enable_i && data_i) ? SHIFT : IDLE;
            SHIFT:   w_next = (r_cnt == CNT_W'(PKT_W - 1)) ? PUSH : SHIFT;
            PUSH:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign pkt_o = r_shift;
endmodule

// File: rtl/wb_deserializer_out.sv
// wb_deserializer_out: Wishbone slave queuing packets received on the serial link.
// Ports: CLK_I/RST_I clock and async active-high reset; data_i serial input;
// irq_o FIFO not empty; busy_o frame in flight; CYC_I/STB_I/WE_I/ADR_I/DAT_I
// Wishbone request; ACK_O/ERR_O combinational responses; DAT_O read data.
module wb_deserializer_out
    import WBDeserializer::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        data_i,
    output logic        irq_o,
    output logic        busy_o,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PKT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wp, r_rp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_enable, r_ovf;

    logic [PKT_W-1:0] w_pkt;
    logic             w_pkt_valid, w_busy;
    logic             w_empty, w_full, w_sel, w_ok, w_pop, w_push, w_drop, w_ctrl_wr;
    logic [1:0]       w_adr;
    logic [31:0]      w_status;
    logic             w_unused;

    deserializer_out u_rx (
        .clk_i       (CLK_I),
        .rst_i       (RST_I),
        .enable_i    (r_enable),
        .data_i      (data_i),
        .pkt_o       (w_pkt),
        .pkt_valid_o (w_pkt_valid),
        .busy_o      (w_busy)
    );

    assign w_unused = ^{ADR_I[31:2], DAT_I[31:2]};

    assign w_adr     = ADR_I[1:0];
    assign w_empty   = r_cnt == '0;
    assign w_full    = r_cnt == CNT_W'(FIFO_DEPTH);
    assign w_sel     = CYC_I & STB_I;
    assign w_ok      = (w_adr == ADR_CTRL) ||
                       (!WE_I && (w_adr == ADR_STATUS || (w_adr == ADR_DATA && !w_empty)));
    assign ACK_O     = w_sel & w_ok;
    assign ERR_O     = w_sel & !w_ok;
    assign w_pop     = ACK_O & !WE_I & (w_adr == ADR_DATA);
    // a pop in the PUSH cycle frees the slot, so a full FIFO still accepts the frame
    assign w_push    = w_pkt_valid & (!w_full | w_pop);
    assign w_drop    = w_pkt_valid & w_full & !w_pop;
    assign w_ctrl_wr = ACK_O & WE_I & (w_adr == ADR_CTRL);
    assign irq_o     = !w_empty;
    assign busy_o    = w_busy;

    always_comb begin
        w_status            = '0;
        w_status[ST_OVF]    = r_ovf;
        w_status[ST_BUSY]   = w_busy;
        w_status[ST_FULL]   = w_full;
        w_status[ST_EMPTY]  = w_empty;
        w_status[CNT_W-1:0] = r_cnt;
    end

    assign DAT_O = (ACK_O && !WE_I) ?
                   (w_adr == ADR_CTRL   ? 32'(r_enable) :
                    w_adr == ADR_STATUS ? w_status      : 32'(r_mem[r_rp])) : '0;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_enable <= 1'b0;
            r_ovf    <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_ctrl_wr)
                r_enable <= DAT_I[CTRL_EN];
            // a drop in the same cycle as a clear leaves overflow set
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_ctrl_wr && DAT_I[CTRL_CLR])
                r_ovf <= 1'b0;
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wp] <= w_pkt;
        end
    end
endmodule

// File: tb/tb_wb_deserializer_out.sv
// tb_wb_deserializer_out: self-checking bench for wb_deserializer_out against a queue model.
module tb_wb_deserializer_out;
    logic        CLK_I = 1'b0, RST_I = 1'b1, data_i = 1'b0;
    logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
    logic [31:0] ADR_I = '0, DAT_I = '0;
    logic        irq_o, busy_o, ACK_O, ERR_O;
    logic [31:0] DAT_O;

    int checks = 0, failures = 0;

    always #5 CLK_I = ~CLK_I;

    wb_deserializer_out dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .data_i (data_i),
        .irq_o  (irq_o),
        .busy_o (busy_o),
        .CYC_I  (CYC_I),
        .STB_I  (STB_I),
        .WE_I   (WE_I),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .ACK_O  (ACK_O),
        .ERR_O  (ERR_O),
        .DAT_O  (DAT_O)
    );

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] wdat;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        chk_dat;
    } vec_t;

    vec_t        vecs[10];
    logic [26:0] q[$];
    logic        m_en = 1'b0, m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK_I);
            data_i = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [26:0] p);
        @(negedge CLK_I);
        data_i = 1'b1;
        for (int i = 26; i >= 0; i--) begin
            @(negedge CLK_I);
            data_i = p[i];
        end
    endtask

    task automatic frame_model(input logic [26:0] p);
        if (m_en) begin
            if (q.size() < 4) q.push_back(p);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {m_ovf, 24'b0, 1'b0, q.size() == 4, q.size() == 0, 1'b0, 3'(q.size())};
    endfunction

    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                       output logic ack, output logic err, output logic [31:0] rdat);
        @(negedge CLK_I);
        data_i = 1'b0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = {30'b0, adr}; DAT_I = wdat;
        #1;
        ack = ACK_O; err = ERR_O; rdat = DAT_O;
        @(posedge CLK_I);
        #1;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic access(input string name, input logic we, input logic [1:0] adr,
                          input logic [31:0] wdat, input logic eack, input logic eerr,
                          input logic [31:0] edat, input logic chk_dat);
        logic        ack, err;
        logic [31:0] rdat;
        bus(we, adr, wdat, ack, err, rdat);
        check({name, " ack"}, 32'(ack), 32'(eack));
        check({name, " err"}, 32'(err), 32'(eerr));
        if (chk_dat) check({name, " dat"}, rdat, edat);
    endtask

    task automatic read_data(input string name);
        logic [31:0] exp;
        if (q.size() == 0) begin
            access(name, 1'b0, 2'd2, '0, 1'b0, 1'b1, '0, 1'b1);
        end else begin
            exp = 32'(q.pop_front());
            access(name, 1'b0, 2'd2, '0, 1'b1, 1'b0, exp, 1'b1);
        end
    endtask

    task automatic read_status(input string name);
        access(name, 1'b0, 2'd1, '0, 1'b1, 1'b0, status_exp(), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [26:0] p;
        logic [26:0] p0;
        logic [31:0] exp;
        logic [31:0] wdat;

        vecs[0] = '{1'b1, 2'd0, 32'h1,        1'b1, 1'b0, 32'h0,  1'b0};
        vecs[1] = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h1,  1'b1};
        vecs[2] = '{1'b0, 2'd1, 32'h0,        1'b1, 1'b0, 32'h10, 1'b1};
        vecs[3] = '{1'b1, 2'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,  1'b1};
        vecs[4] = '{1'b0, 2'd3, 32'h0,        1'b0, 1'b1, 32'h0,  1'b1};
        vecs[5] = '{1'b1, 2'd3, 32'h0,        1'b0, 1'b1, 32'h0,  1'b1};
        vecs[6] = '{1'b0, 2'd2, 32'h0,        1'b0, 1'b1, 32'h0,  1'b1};
        vecs[7] = '{1'b1, 2'd2, 32'h3,        1'b0, 1'b1, 32'h0,  1'b1};
        vecs[8] = '{1'b0, 2'd1, 32'h0,        1'b1, 1'b0, 32'h10, 1'b1};
        vecs[9] = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h1,  1'b1};

        repeat (3) @(negedge CLK_I);
        check("rst irq", 32'(irq_o), 0);
        check("rst busy", 32'(busy_o), 0);
        check("rst ack", 32'(ACK_O), 0);
        check("rst err", 32'(ERR_O), 0);
        check("rst dat", DAT_O, 0);
        RST_I = 1'b0;
        access("rst ctrl", 1'b0, 2'd0, '0, 1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 10; i++)
            access($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].wdat,
                   vecs[i].ack, vecs[i].err, vecs[i].dat, vecs[i].chk_dat);
        m_en = 1'b1;

        p0 = {1'b0, 8'h5A, 1'b1, 8'hA5, 1'b0, 8'h3C};
        send_frame(p0);
        @(negedge CLK_I);
        data_i = 1'b0;
        check("irq lat1", 32'(irq_o), 0);
        check("busy push", 32'(busy_o), 1);
        @(negedge CLK_I);
        check("irq lat2", 32'(irq_o), 1);
        check("busy idle", 32'(busy_o), 0);
        frame_model(p0);
        read_data("pkt0");
        check("irq after read", 32'(irq_o), 0);
        read_status("status empty");

        access("disable", 1'b1, 2'd0, 32'h0, 1'b1, 1'b0, '0, 1'b0);
        m_en = 1'b0;
        send_frame(27'h1ABCDEF);
        frame_model(27'h1ABCDEF);
        idle(3);
        read_status("status disabled");
        read_data("data disabled");

        access("enable", 1'b1, 2'd0, 32'h1, 1'b1, 1'b0, '0, 1'b0);
        m_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            p = 27'($urandom);
            send_frame(p);
            idle(1);
            frame_model(p);
        end
        read_status("status overflow");
        check("irq full", 32'(irq_o), 1);
        for (int i = 0; i < 5; i++) read_data($sformatf("ovf read%0d", i));

        access("clear ovf", 1'b1, 2'd0, 32'h3, 1'b1, 1'b0, '0, 1'b0);
        m_ovf = 1'b0;
        read_status("status cleared");

        for (int i = 0; i < 4; i++) begin
            p = 27'($urandom);
            send_frame(p);
            idle(1);
            frame_model(p);
        end
        p = 27'($urandom);
        send_frame(p);
        exp = 32'(q.pop_front());
        access("coincide pop", 1'b0, 2'd2, '0, 1'b1, 1'b0, exp, 1'b1);
        frame_model(p);
        idle(1);
        read_status("status coincide");
        for (int i = 0; i < 5; i++) read_data($sformatf("coincide read%0d", i));

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    p = 27'($urandom);
                    send_frame(p);
                    idle(1);
                    frame_model(p);
                end
                2, 3: read_data("rnd data");
                4: read_status("rnd status");
                default: begin
                    wdat = {30'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0};
                    access("rnd ctrl wr", 1'b1, 2'd0, wdat, 1'b1, 1'b0, '0, 1'b0);
                    m_en = wdat[0];
                    if (wdat[1]) m_ovf = 1'b0;
                    access("rnd ctrl rd", 1'b0, 2'd0, '0, 1'b1, 1'b0, 32'(m_en), 1'b1);
                end
            endcase
        end

        access("pre-reset en", 1'b1, 2'd0, 32'h1, 1'b1, 1'b0, '0, 1'b0);
        m_en = 1'b1;
        p = 27'($urandom);
        send_frame(p);
        idle(1);
        frame_model(p);
        @(negedge CLK_I);
        data_i = 1'b1;
        for (int i = 26; i >= 13; i--) begin
            @(negedge CLK_I);
            data_i = p[i];
        end
        @(posedge CLK_I);
        check("pre-reset busy", 32'(busy_o), 1);
        check("pre-reset irq", 32'(irq_o), 1);
        #3;
        RST_I = 1'b1;
        data_i = 1'b0;
        #1;
        check("async rst busy", 32'(busy_o), 0);
        check("async rst irq", 32'(irq_o), 0);
        q.delete();
        m_en = 1'b0;
        m_ovf = 1'b0;
        @(negedge CLK_I);
        RST_I = 1'b0;
        read_status("post-reset status");
        access("post-reset ctrl", 1'b0, 2'd0, '0, 1'b1, 1'b0, 32'h0, 1'b1);
        access("re-enable", 1'b1, 2'd0, 32'h1, 1'b1, 1'b0, '0, 1'b0);
        m_en = 1'b1;
        p = 27'($urandom);
        send_frame(p);
        idle(2);
        frame_model(p);
        read_data("post-reset data");
        read_status("final status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
